bs_rr_schdlr: RTL and testbench

- Single-bus transfer scheduler for the 6-driver parallel bus fabric.
- Grants one driver at a time using round-robin order, pops that driver's FIFO head, and decodes the destination ID from the packet header.
- Pushes the packet to the destination FIFO, or to every other driver's FIFO for broadcast. A push waits until every target FIFO reports not-full.
- Counts packets that are dropped because their destination is invalid.

---
 rtl/bs_rr_schdlr_if.sv | 25 ++
 rtl/bs_rr_schdlr.sv | 153 +++++++++++++++
 tb/tb_bs_rr_schdlr.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bs_rr_schdlr_if.sv
// Bus-side signals between the per-driver FIFOs and the round-robin scheduler.
// The scheduler takes the master view; the FIFO side takes the slave view.
interface bs_rr_schdlr_if #(
    parameter int unsigned Drvrs = 6,
    parameter int unsigned Bits  = 32
);
    logic [Drvrs-1:0]      pndng;
    logic [Drvrs*Bits-1:0] D_pop;
    logic [Drvrs-1:0]      full;
    logic [Drvrs-1:0]      pop;
    logic [Drvrs-1:0]      push;
    logic [Bits-1:0]       D_push;
    logic                  busy;
    logic [15:0]           err_cnt;

    modport master (
        input  pndng, D_pop, full,
        output pop, push, D_push, busy, err_cnt
    );

    modport slave (
        output pndng, D_pop, full,
        input  pop, push, D_push, busy, err_cnt
    );
endinterface

// File: rtl/bs_rr_schdlr.sv
// Round-robin bus scheduler: grants one driver at a time, pops its FIFO head and
// pushes the packet to the destination FIFO(s) once every target has room.
module bs_rr_schdlr #(
    parameter int unsigned       Drvrs     = 6,
    parameter int unsigned       Bits      = 32,
    parameter int unsigned       IdBits    = 8,
    parameter logic [IdBits-1:0] Broadcast = {IdBits{1'b1}}
) (
    input logic            clk,
    input logic            reset,
    bs_rr_schdlr_if.master bus
);
    localparam int unsigned IdxW = $clog2(Drvrs);

    typedef enum logic [1:0] {StIdle, StPop, StWait, StPush} state_e;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  last_q, last_d;
    logic [IdxW-1:0]  gnt_q, gnt_d;
    logic [Bits-1:0]  data_q, data_d;
    logic [Bits-1:0]  d_push_q, d_push_d;
    logic [Drvrs-1:0] mask_q, mask_d;
    logic [Drvrs-1:0] pop_q, pop_d;
    logic [Drvrs-1:0] push_q, push_d;
    logic             busy_q, busy_d;
    logic [15:0]      err_cnt_q, err_cnt_d;

    logic             rr_found;
    logic [IdxW-1:0]  rr_pick;
    logic [Bits-1:0]  head;
    logic [IdBits-1:0] dest;
    logic [Drvrs-1:0] tgt_mask;

    // First pending driver strictly after the last grant, wrapping around.
    always_comb begin
        int unsigned j;
        j        = 0;
        rr_found = 1'b0;
        rr_pick  = last_q;
        for (int unsigned i = 1; i <= Drvrs; i++) begin
            j = 32'(last_q) + i;
            if (j >= Drvrs) begin
                j = j - Drvrs;
            end
            if (!rr_found && bus.pndng[j]) begin
                rr_found = 1'b1;
                rr_pick  = IdxW'(j);
            end
        end
    end

    assign head = bus.D_pop[Bits*gnt_q +: Bits];
    assign dest = head[Bits-1 -: IdBits];

    // Broadcast excludes the source; a direct ID equal to the source is loopback.
    always_comb begin
        tgt_mask = '0;
        if (dest == Broadcast) begin
            tgt_mask = ~(Drvrs'(1) << gnt_q);
        end else if (32'(dest) < Drvrs) begin
            tgt_mask = Drvrs'(1) << dest;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        data_d    = data_q;
        mask_d    = mask_q;
        pop_d     = '0;
        push_d    = '0;
        d_push_d  = d_push_q;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (rr_found) begin
                    gnt_d   = rr_pick;
                    last_d  = rr_pick;
                    pop_d   = Drvrs'(1) << rr_pick;
                    state_d = StPop;
                end
            end
            StPop: begin
                data_d = head;
                mask_d = tgt_mask;
                if (tgt_mask == '0) begin
                    if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                    state_d = StIdle;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // Holds indefinitely; other requesters are blocked behind this packet.
                if ((mask_q & bus.full) == '0) begin
                    push_d   = mask_q;
                    d_push_d = data_q;
                    state_d  = StPush;
                end
            end
            StPush: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            last_q    <= IdxW'(Drvrs - 1);
            gnt_q     <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            pop_q     <= '0;
            push_q    <= '0;
            d_push_q  <= '0;
            busy_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
            pop_q     <= pop_d;
            push_q    <= push_d;
            d_push_q  <= d_push_d;
            busy_q    <= busy_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.pop     = pop_q;
    assign bus.push    = push_q;
    assign bus.D_push  = d_push_q;
    assign bus.busy    = busy_q;
    assign bus.err_cnt = err_cnt_q;

    a_pop_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(pop_q));
    a_pop_push_excl : assert property (@(posedge clk) disable iff (reset)
        !((|pop_q) && (|push_q)));
    a_push_only_in_push : assert property (@(posedge clk) disable iff (reset)
        (|push_q) |-> (state_q == StPush));
endmodule

// File: tb/tb_bs_rr_schdlr.sv
// Bench for bs_rr_schdlr: directed scenarios plus random traffic, checked against a
// transaction-level timeline model of grants, pops, pushes and drops.
module tb_bs_rr_schdlr;
    localparam int unsigned N = 6;
    localparam int unsigned W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    bs_rr_schdlr_if #(.Drvrs(N), .Bits(W)) bus ();

    bs_rr_schdlr #(
        .Drvrs    (N),
        .Bits     (W),
        .IdBits   (8),
        .Broadcast(8'hFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    logic [W-1:0] fifo [N][$];

    // Timeline model: cycle numbers of the expected events of the current transfer.
    int           pop_at    = -1;
    int           push_at   = -1;
    int           busy_end  = -1;
    int           err_at    = -1;
    int           idle_from = 0;
    int           m_last    = N - 1;
    int           m_src     = 0;
    bit           resolving = 1'b0;
    logic [N-1:0] m_mask    = '0;
    logic [W-1:0] m_data    = '0;
    logic [W-1:0] exp_dpush = '0;
    logic [15:0]  exp_err   = '0;
    int           pend_src  = -1;

    bit           full_rand = 1'b0;
    logic [N-1:0] full_val  = '0;
    bit           rst_req   = 1'b1;

    int           pop_log[$];
    int           pop_cyc_log[$];
    logic [N-1:0] push_log[$];
    logic [W-1:0] last_dpush;
    int           push_cyc;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    function automatic int rr_next(input int last);
        for (int i = 1; i <= int'(N); i++) begin
            int k;
            k = (last + i) % int'(N);
            if (fifo[k].size() != 0) return k;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] targets(input logic [W-1:0] d, input int src);
        logic [7:0] id;
        id = d[W-1 -: 8];
        if (id == 8'hFF) return ~oh(src);
        if (int'(id) < int'(N)) return oh(int'(id));
        return '0;
    endfunction

    function automatic logic [W-1:0] pkt(input logic [7:0] id);
        return {id, 24'($urandom())};
    endfunction

    task automatic clear_logs();
        pop_log.delete();
        pop_cyc_log.delete();
        push_log.delete();
        last_dpush = '0;
        push_cyc   = -1;
    endtask

    // One clock cycle: check outputs, update FIFOs, drive inputs, advance the model.
    task automatic step();
        logic [N-1:0]   ep, eh, full_now, pndng_now;
        logic [N*W-1:0] dp;
        bit             eb;
        int             g;

        @(negedge clk);
        cyc++;

        ep = (cyc == pop_at) ? oh(m_src) : '0;
        eh = (cyc == push_at) ? m_mask : '0;
        if (cyc == push_at) exp_dpush = m_data;
        if (cyc == err_at && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
        eb = (pop_at >= 0) && (cyc >= pop_at) && (busy_end < 0 || cyc <= busy_end);

        check_eq("pop", bus.pop, ep);
        check_eq("push", bus.push, eh);
        check_eq("d_push", bus.D_push, exp_dpush);
        check_eq("busy", bus.busy, eb);
        check_eq("err_cnt", bus.err_cnt, exp_err);

        for (int i = 0; i < int'(N); i++) begin
            if (bus.pop[i]) begin
                pop_log.push_back(i);
                pop_cyc_log.push_back(cyc);
            end
        end
        if (bus.push != '0) begin
            push_log.push_back(bus.push);
            last_dpush = bus.D_push;
            push_cyc   = cyc;
        end

        // A pop strobe takes effect at the edge that ends its cycle.
        if (pend_src >= 0) void'(fifo[pend_src].pop_front());
        pend_src = (cyc == pop_at) ? m_src : -1;

        for (int i = 0; i < int'(N); i++) begin
            pndng_now[i]    = (fifo[i].size() != 0);
            dp[i*W +: W]    = (fifo[i].size() != 0) ? fifo[i][0] : $urandom();
            full_now[i]     = full_rand ? ($urandom_range(0, 2) == 0) : full_val[i];
        end
        bus.pndng  = pndng_now;
        bus.D_pop  = dp;
        bus.full   = full_now;
        reset      = rst_req;

        if (rst_req) begin
            pop_at    = -1;
            push_at   = -1;
            busy_end  = -1;
            err_at    = -1;
            resolving = 1'b0;
            exp_dpush = '0;
            exp_err   = '0;
            m_last    = N - 1;
            idle_from = cyc + 1;
        end else if (resolving) begin
            if (cyc >= pop_at + 1 && (full_now & m_mask) == '0) begin
                push_at   = cyc + 1;
                busy_end  = cyc + 1;
                idle_from = cyc + 2;
                resolving = 1'b0;
            end
        end else if (cyc >= idle_from && pndng_now != '0) begin
            g       = rr_next(m_last);
            m_last  = g;
            m_src   = g;
            pop_at  = cyc + 1;
            push_at = -1;
            m_data  = fifo[g][0];
            m_mask  = targets(m_data, g);
            if (m_mask == '0) begin
                err_at    = cyc + 2;
                busy_end  = cyc + 1;
                idle_from = cyc + 2;
            end else begin
                resolving = 1'b1;
                busy_end  = -1;
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        for (int i = 0; i < int'(N); i++) fifo[i].delete();
        pend_src = -1;
        steps(2);
        rst_req = 1'b0;
    endtask

    initial begin
        bus.pndng = '0;
        bus.D_pop = '0;
        bus.full  = '0;

        // Single packet, first grant after reset.
        do_reset();
        clear_logs();
        full_val = '0;
        fifo[0].push_back(32'h0300_00AA);
        steps(6);
        check_eq("t1_npop", pop_log.size(), 1);
        check_eq("t1_src", pop_log[0], 0);
        check_eq("t1_push", push_log[0], 6'b001000);
        check_eq("t1_dpush", last_dpush, 32'h0300_00AA);
        check_eq("t1_lat", push_cyc - pop_cyc_log[0], 2);

        // All drivers pending: strict rotation, one pop every 4 cycles.
        do_reset();
        clear_logs();
        for (int i = 0; i < int'(N); i++) fifo[i].push_back(pkt(8'h00));
        fifo[0].push_back(pkt(8'h00));
        steps(32);
        check_eq("t2_npop", pop_log.size(), 7);
        for (int k = 0; k < 7; k++) check_eq("t2_order", pop_log[k], k % int'(N));
        for (int k = 1; k < 7; k++) check_eq("t2_gap", pop_cyc_log[k] - pop_cyc_log[k-1], 4);

        // Broadcast from driver 2.
        do_reset();
        clear_logs();
        fifo[2].push_back(32'hFF00_1234);
        steps(8);
        check_eq("t3_npush", push_log.size(), 1);
        check_eq("t3_mask", push_log[0], 6'b111011);
        check_eq("t3_dpush", last_dpush, 32'hFF00_1234);

        // Destination full: head-of-line blocking until it drains.
        do_reset();
        clear_logs();
        full_val = 6'b010000;
        fifo[1].push_back(pkt(8'h04));
        fifo[3].push_back(pkt(8'h00));
        steps(12);
        check_eq("t4_held_pops", pop_log.size(), 1);
        check_eq("t4_held_push", push_log.size(), 0);
        full_val = '0;
        steps(12);
        check_eq("t4_npop", pop_log.size(), 2);
        check_eq("t4_second", pop_log[1], 3);
        check_eq("t4_push4", push_log[0], 6'b010000);

        // Invalid destination is dropped and counted; counter saturates.
        do_reset();
        clear_logs();
        fifo[5].push_back(pkt(8'h09));
        steps(6);
        check_eq("t5_pop5", pop_log[0], 5);
        check_eq("t5_nopush", push_log.size(), 0);
        check_eq("t5_err1", bus.err_cnt, 16'd1);
        force dut.err_cnt_q = 16'hFFFE;
        exp_err = 16'hFFFE;
        steps(2);
        release dut.err_cnt_q;
        fifo[5].push_back(pkt(8'h09));
        fifo[5].push_back(pkt(8'h7F));
        steps(10);
        check_eq("t5_sat", bus.err_cnt, 16'hFFFF);

        // Reset while a packet waits: it is discarded and the pointer restarts.
        do_reset();
        clear_logs();
        full_val = 6'b010000;
        fifo[1].push_back(pkt(8'h04));
        steps(6);
        check_eq("t6_busy", bus.busy, 1'b1);
        do_reset();
        clear_logs();
        full_val = '0;
        fifo[3].push_back(pkt(8'h01));
        fifo[0].push_back(pkt(8'h02));
        steps(12);
        check_eq("t6_first", pop_log[0], 0);
        check_eq("t6_npush", push_log.size(), 2);

        // Random traffic with random backpressure.
        do_reset();
        clear_logs();
        full_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (fifo[i].size() < 3 && $urandom_range(0, 3) == 0) begin
                    int r;
                    r = $urandom_range(0, 9);
                    if (r < 6) fifo[i].push_back(pkt(8'(r)));
                    else if (r < 8) fifo[i].push_back(pkt(8'hFF));
                    else fifo[i].push_back(pkt(8'($urandom_range(6, 254))));
                end
            end
            step();
        end
        full_rand = 1'b0;
        full_val  = '0;
        steps(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
